fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined RISC-V core. Owns the program counter, drives `Inst_Address` into the combinational instruction memory, captures the returned 32-bit `Instruction` into the IF/ID pipeline register, and handles stall, branch redirect and flush. It also detects end-of-program and illegal fetch targets, and counts delivered instructions.

## Interface
- `RESET_PC`, 64'h0, PC value loaded on reset.
- `MEM_BYTES`, 72, size of instruction memory in bytes; a legal fetch address A satisfies A+3 <= MEM_BYTES-1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `Stall` input 1: hold PC and IF/ID contents (hazard unit).
- `Branch_Taken` input 1: redirect request from EX.
- `Branch_Target` input 64: redirect address, valid when `Branch_Taken`=1.
- `Instruction` input 32: instruction memory read data for `Inst_Address`.
- `Inst_Address` output 64: current PC, to instruction memory.
- `IF_ID_PC` output 64: PC of the captured instruction.
- `IF_ID_Instruction` output 32: captured instruction.
- `IF_ID_Valid` output 1: captured instruction is real (0 = bubble).
- `Halted` output 1: fetch is parked past the last instruction.
- `Fault` output 1: sticky illegal-redirect flag.
- `Fault_Addr` output 64: offending `Branch_Target`.
- `Fetch_Count` output 32: number of instructions loaded with `IF_ID_Valid`=1.

## Operation
- Reset values: PC=`RESET_PC`, state RUN, `IF_ID_PC`=0, `IF_ID_Instruction`=32'h00000013 (NOP), `IF_ID_Valid`=0, `Halted`=0, `Fault`=0, `Fault_Addr`=0, `Fetch_Count`=0.
- `Inst_Address` = PC, combinational from the PC register.
- Bubble = `IF_ID_Valid`<=0, `IF_ID_Instruction`<=NOP, `IF_ID_PC`<=0.
- Illegal target T: T[1:0]!=0, or T+3 > MEM_BYTES-1 (computed in 64-bit arithmetic; no wrap).
- State RUN, per-cycle priority:
  1. `Branch_Taken` with legal T: PC<=T, insert bubble (flush), state RUN. This overrides `Stall`.
  2. `Branch_Taken` with illegal T: `Fault_Addr`<=T, `Fault`<=1, insert bubble, PC held, state FAULT.
  3. `Stall`: PC and IF/ID held, counter held.
  4. Otherwise: `IF_ID_PC`<=PC, `IF_ID_Instruction`<=`Instruction`, `IF_ID_Valid`<=1, `Fetch_Count`++ (wraps at 2^32). If PC+4+3 > MEM_BYTES-1, PC is held and state goes to HALT; otherwise PC<=PC+4.
- State HALT: `Halted`=1. Each unstalled cycle inserts a bubble. A legal `Branch_Taken` sets PC<=T, inserts a bubble, `Halted`<=0, state RUN. An illegal one goes to FAULT as in RUN. `Stall` without a branch holds IF/ID.
- State FAULT: `Fault`=1. Inserts a bubble every cycle regardless of `Stall`. Ignores `Branch_Taken`. Exits only on `reset`.
- `Halted` and `Fault` are registered outputs that reflect the current state.

## Timing
- Fetch is single-cycle: the instruction for PC in cycle N appears on `IF_ID_*` in cycle N+1.
- Redirect with `Branch_Taken` in cycle N: `IF_ID_Valid`=0 in N+1 and `Inst_Address`=T in N+1. The target instruction is valid on `IF_ID_*` in N+2.
- Stall in cycle N: `Inst_Address` and `IF_ID_*` in N+1 equal their values in N.
- HALT entry: the last instruction is valid in the cycle after it was fetched. `Halted`=1 in that same cycle, and `IF_ID_Valid`=0 from the following cycle.
- Simultaneous `Stall`+`Branch_Taken`: the branch wins.
- Reset asserted mid-stream: reset values apply at the next edge, overriding all other inputs.

## Test plan
- Reset, then run 3 unstalled cycles with `RESET_PC`=0 -> `IF_ID_Instruction` = 0x04b68463, 0x00d00733, 0x01400ab3 with `IF_ID_PC` = 0, 4, 8, `IF_ID_Valid`=1, `Fetch_Count`=3.
- `Stall` held 2 cycles while `IF_ID_PC`=8 -> `IF_ID_*` and `Inst_Address`=0xC unchanged. Release -> next capture is 0x02b70863 @0xC.
- `Branch_Taken` with `Branch_Target`=0x18, together with `Stall`=1 -> next cycle is a bubble (`IF_ID_Valid`=0, NOP). The cycle after shows 0x000C3B03 @0x18.
- Free-run to 0x44 -> 0xfa000ee3 @0x44 captured with `Valid`=1 and `Halted`=1, then bubbles. `Branch_Taken` to 0x0 -> `Halted`=0 and 0x04b68463 is fetched again.
- `Branch_Taken` to 0x1A -> `Fault`=1, `Fault_Addr`=0x1A, bubbles thereafter. A later legal branch to 0x0 is ignored.
- `Branch_Taken` to 0x48 (out of range) -> `Fault`=1. Assert `reset` for one cycle -> all outputs return to reset values and fetch resumes at 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, IF/ID register, stall/redirect/halt/fault
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          MEM_BYTES = 72
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [63:0] Branch_Target,
    input  logic [31:0] Instruction,
    output logic [63:0] Inst_Address,
    output logic [63:0] IF_ID_PC,
    output logic [31:0] IF_ID_Instruction,
    output logic        IF_ID_Valid,
    output logic        Halted,
    output logic        Fault,
    output logic [63:0] Fault_Addr,
    output logic [31:0] Fetch_Count
);

    localparam logic [31:0] NOP       = 32'h0000_0013;
    // Widened by one bit so address+offset comparisons can never wrap.
    localparam logic [64:0] LAST_BYTE = 65'(MEM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_FAULT
    } state_t;

    state_t      state_q;
    logic [63:0] pc_q;
    logic [63:0] if_id_pc_q;
    logic [31:0] if_id_instr_q;
    logic        if_id_valid_q;
    logic        halted_q;
    logic        fault_q;
    logic [63:0] fault_addr_q;
    logic [31:0] fetch_count_q;

    logic        target_legal_d;
    logic        last_fetch_d;
    logic [63:0] pc_inc_d;
    logic [31:0] fetch_count_inc_d;

    // Legality of the redirect target and whether the word after PC would run off memory.
    always_comb begin
        target_legal_d    = (Branch_Target[1:0] == 2'b00) &&
                            (({1'b0, Branch_Target} + 65'd3) <= LAST_BYTE);
        last_fetch_d      = (({1'b0, pc_q} + 65'd7) > LAST_BYTE);
        pc_inc_d          = pc_q + 64'd4;
        fetch_count_inc_d = fetch_count_q + 32'd1;
    end

    // Fetch FSM: PC, IF/ID register, status flags and delivered-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 64'd0;
            if_id_instr_q <= NOP;
            if_id_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            fault_addr_q  <= 64'd0;
            fetch_count_q <= 32'd0;
        end else begin
            unique case (state_q)
                ST_FAULT: begin
                    // Parked until reset; keep feeding bubbles downstream.
                    if_id_pc_q    <= 64'd0;
                    if_id_instr_q <= NOP;
                    if_id_valid_q <= 1'b0;
                end
                default: begin
                    if (Branch_Taken) begin
                        // Redirect wins over stall and always flushes IF/ID.
                        if_id_pc_q    <= 64'd0;
                        if_id_instr_q <= NOP;
                        if_id_valid_q <= 1'b0;
                        halted_q      <= 1'b0;
                        if (target_legal_d) begin
                            pc_q    <= Branch_Target;
                            state_q <= ST_RUN;
                        end else begin
                            fault_q      <= 1'b1;
                            fault_addr_q <= Branch_Target;
                            state_q      <= ST_FAULT;
                        end
                    end else if (!Stall) begin
                        if (state_q == ST_HALT) begin
                            if_id_pc_q    <= 64'd0;
                            if_id_instr_q <= NOP;
                            if_id_valid_q <= 1'b0;
                        end else begin
                            if_id_pc_q    <= pc_q;
                            if_id_instr_q <= Instruction;
                            if_id_valid_q <= 1'b1;
                            fetch_count_q <= fetch_count_inc_d;
                            if (last_fetch_d) begin
                                halted_q <= 1'b1;
                                state_q  <= ST_HALT;
                            end else begin
                                pc_q <= pc_inc_d;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign Inst_Address      = pc_q;
    assign IF_ID_PC          = if_id_pc_q;
    assign IF_ID_Instruction = if_id_instr_q;
    assign IF_ID_Valid       = if_id_valid_q;
    assign Halted            = halted_q;
    assign Fault             = fault_q;
    assign Fault_Addr        = fault_addr_q;
    assign Fetch_Count       = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed bench for fetch_unit against a behavioural model
module tb_fetch_unit;

    localparam int          MEM_BYTES = 72;
    localparam int          WORDS     = MEM_BYTES / 4;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic [63:0] Branch_Target = 64'd0;
    logic [31:0] Instruction;
    logic [63:0] Inst_Address;
    logic [63:0] IF_ID_PC;
    logic [31:0] IF_ID_Instruction;
    logic        IF_ID_Valid;
    logic        Halted;
    logic        Fault;
    logic [63:0] Fault_Addr;
    logic [31:0] Fetch_Count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [WORDS];

    fetch_unit #(.RESET_PC(64'h0), .MEM_BYTES(MEM_BYTES)) dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (Stall),
        .Branch_Taken     (Branch_Taken),
        .Branch_Target    (Branch_Target),
        .Instruction      (Instruction),
        .Inst_Address     (Inst_Address),
        .IF_ID_PC         (IF_ID_PC),
        .IF_ID_Instruction(IF_ID_Instruction),
        .IF_ID_Valid      (IF_ID_Valid),
        .Halted           (Halted),
        .Fault            (Fault),
        .Fault_Addr       (Fault_Addr),
        .Fetch_Count      (Fetch_Count)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory
    always_comb begin
        if (Inst_Address < 64'(MEM_BYTES))
            Instruction = mem[Inst_Address[6:2]];
        else
            Instruction = 32'd0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = fetching, 1 = parked past the end, 2 = faulted
    int          m_mode;
    logic [63:0] m_pc, m_ifpc, m_faddr;
    logic [31:0] m_ifinstr, m_count;
    logic        m_valid, m_fault;
    bit          m_ready = 0;

    function automatic bit fits(input logic [63:0] a);
        return (a % 4 == 0) && (a <= 64'(MEM_BYTES - 4));
    endfunction

    task automatic m_bubble();
        m_valid = 0; m_ifinstr = NOP; m_ifpc = 0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_pc = 0; m_count = 0; m_fault = 0; m_faddr = 0;
            m_bubble();
            m_ready = 1;
        end else if (m_ready) begin
            if (m_mode == 2) begin
                m_bubble();
            end else if (Branch_Taken) begin
                m_bubble();
                if (fits(Branch_Target)) begin
                    m_pc = Branch_Target; m_mode = 0;
                end else begin
                    m_fault = 1; m_faddr = Branch_Target; m_mode = 2;
                end
            end else if (!Stall) begin
                if (m_mode == 1) begin
                    m_bubble();
                end else begin
                    m_ifpc = m_pc; m_ifinstr = mem[m_pc / 4]; m_valid = 1;
                    m_count = m_count + 1;
                    if (fits(m_pc + 4)) m_pc = m_pc + 4;
                    else m_mode = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_ready) begin
            chk("Inst_Address", Inst_Address, m_pc);
            chk("IF_ID_PC", IF_ID_PC, m_ifpc);
            chk("IF_ID_Instruction", 64'(IF_ID_Instruction), 64'(m_ifinstr));
            chk("IF_ID_Valid", 64'(IF_ID_Valid), 64'(m_valid));
            chk("Halted", 64'(Halted), 64'(m_mode == 1));
            chk("Fault", 64'(Fault), 64'(m_fault));
            chk("Fault_Addr", Fault_Addr, m_faddr);
            chk("Fetch_Count", 64'(Fetch_Count), 64'(m_count));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic s, input logic b, input logic [63:0] t);
        Stall = s; Branch_Taken = b; Branch_Target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string name, input logic [31:0] instr, input logic [63:0] pc);
        chk({name, "_instr"}, 64'(IF_ID_Instruction), 64'(instr));
        chk({name, "_pc"}, IF_ID_PC, pc);
        chk({name, "_valid"}, 64'(IF_ID_Valid), 64'd1);
    endtask

    task automatic chk_bubble(input string name);
        chk({name, "_valid"}, 64'(IF_ID_Valid), 64'd0);
        chk({name, "_instr"}, 64'(IF_ID_Instruction), 64'(NOP));
        chk({name, "_pc"}, IF_ID_PC, 64'd0);
    endtask

    task automatic chk_reset_state(input string name);
        chk_bubble(name);
        chk({name, "_addr"}, Inst_Address, 64'd0);
        chk({name, "_halted"}, 64'(Halted), 64'd0);
        chk({name, "_fault"}, 64'(Fault), 64'd0);
        chk({name, "_faddr"}, Fault_Addr, 64'd0);
        chk({name, "_count"}, 64'(Fetch_Count), 64'd0);
    endtask

    initial begin
        int n;
        logic [63:0] tgt;
        logic s, b;

        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0]  = 32'h04b68463;
        mem[1]  = 32'h00d00733;
        mem[2]  = 32'h01400ab3;
        mem[3]  = 32'h02b70863;
        mem[6]  = 32'h000C3B03;
        mem[17] = 32'hfa000ee3;

        // Reset
        reset = 1'b1;
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk_reset_state("reset");
        reset = 1'b0;

        // Three straight fetches
        tick(0, 0, 0); chk_fetch("run0", 32'h04b68463, 64'h0);
        tick(0, 0, 0); chk_fetch("run1", 32'h00d00733, 64'h4);
        tick(0, 0, 0); chk_fetch("run2", 32'h01400ab3, 64'h8);
        chk("run2_count", 64'(Fetch_Count), 64'd3);

        // Stall for two cycles
        tick(1, 0, 0); chk_fetch("stall0", 32'h01400ab3, 64'h8);
        chk("stall0_addr", Inst_Address, 64'hC);
        tick(1, 0, 0); chk_fetch("stall1", 32'h01400ab3, 64'h8);
        chk("stall1_addr", Inst_Address, 64'hC);
        chk("stall1_count", 64'(Fetch_Count), 64'd3);
        tick(0, 0, 0); chk_fetch("release", 32'h02b70863, 64'hC);

        // Branch together with stall: branch wins
        tick(1, 1, 64'h18); chk_bubble("redirect");
        chk("redirect_addr", Inst_Address, 64'h18);
        tick(0, 0, 0); chk_fetch("target", 32'h000C3B03, 64'h18);

        // Free-run to the last word
        n = 0;
        while (!(IF_ID_Valid === 1'b1 && IF_ID_PC === 64'h44) && n < 30) begin
            tick(0, 0, 0);
            n++;
        end
        chk("reach_end_in_budget", 64'(n < 30), 64'd1);
        chk_fetch("last", 32'hfa000ee3, 64'h44);
        chk("last_halted", 64'(Halted), 64'd1);
        tick(0, 0, 0); chk_bubble("halt_bub0");
        tick(0, 0, 0); chk_bubble("halt_bub1");
        chk("halt_addr", Inst_Address, 64'h44);
        tick(0, 1, 64'h0); chk_bubble("unhalt");
        chk("unhalt_halted", 64'(Halted), 64'd0);
        tick(0, 0, 0); chk_fetch("refetch", 32'h04b68463, 64'h0);

        // Misaligned target -> fault, later branches ignored
        tick(0, 1, 64'h1A); chk_bubble("fault_mis");
        chk("fault_mis_flag", 64'(Fault), 64'd1);
        chk("fault_mis_addr", Fault_Addr, 64'h1A);
        chk("fault_mis_pc", Inst_Address, 64'h4);
        tick(0, 1, 64'h0); chk_bubble("fault_ignore");
        chk("fault_ignore_pc", Inst_Address, 64'h4);
        chk("fault_ignore_flag", 64'(Fault), 64'd1);

        // Out-of-range target -> fault, then reset recovers
        reset = 1'b1; tick(0, 0, 0); reset = 1'b0;
        tick(0, 1, 64'h48);
        chk("fault_range_flag", 64'(Fault), 64'd1);
        chk("fault_range_addr", Fault_Addr, 64'h48);
        reset = 1'b1; tick(0, 1, 64'h8); reset = 1'b0;
        chk_reset_state("reset2");
        tick(0, 0, 0); chk_fetch("resume", 32'h04b68463, 64'h0);

        // Legal boundary target
        tick(0, 1, 64'h44); chk_bubble("edge_branch");
        tick(0, 0, 0); chk_fetch("edge_fetch", 32'hfa000ee3, 64'h44);
        chk("edge_halted", 64'(Halted), 64'd1);

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 99) < 12);
            case ($urandom_range(0, 9))
                7: tgt = ($urandom_range(0, 1) != 0) ? 64'h44 : 64'h48;
                8: tgt = 64'($urandom_range(0, 80)) | 64'h1;
                9: tgt = 64'hFFFF_FFFF_FFFF_FFFC;
                default: tgt = 64'($urandom_range(0, WORDS - 1)) << 2;
            endcase
            reset = ($urandom_range(0, 99) < 3);
            tick(s, b, tgt);
        end
        reset = 1'b0;
        tick(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
